// File: rtl/warp_icache.sv
// warp_icache: direct-mapped instruction cache for the fetch stage.
// Returns the 64 bits starting at a halfword-aligned PC, realigned so that
// bits [31:0] hold the instruction at PC. Hits answer one cycle after the
// request. Misses refill 32-byte lines (4 x 64-bit beats) from a backing
// memory. A fetch that straddles two lines waits until both are resident.
module warp_icache #(
  parameter int NUM_LINES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ren,
  input  logic [63:0] i_raddr,
  output logic        o_valid,
  output logic [63:0] o_rdata,
  input  logic        i_flush,
  output logic        o_refill_valid,
  output logic [63:0] o_refill_addr,
  input  logic        i_refill_ready,
  input  logic        i_refill_beat,
  input  logic [63:0] i_refill_data
);

  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = 59 - IDX;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REQ,
    FILL
  } state_t;

  state_t state;

  // Latched fetch address; bit 0 is always treated as zero so it is not kept.
  logic [63:1] addr;
  logic        raddr_lsb_unused;

  // Cache storage.
  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [63:0]       data_mem [NUM_LINES][4];
  logic [NUM_LINES-1:0] valid;

  // Refill bookkeeping.
  logic [IDX-1:0]   victim_idx;
  logic [TAG_W-1:0] victim_tag;
  logic [1:0]       beat_cnt;
  logic             flush_pend;

  // Lookup decode.
  logic [58:0]      line_a;
  logic [58:0]      line_b;
  logic [IDX-1:0]   idx_a;
  logic [IDX-1:0]   idx_b;
  logic [TAG_W-1:0] tag_a;
  logic [TAG_W-1:0] tag_b;
  logic [1:0]       word_sel;
  logic [1:0]       half_sel;
  logic             need_b;
  logic             hit_a;
  logic             hit_b;
  logic             hit;
  logic [63:0]      word_lo;
  logic [63:0]      word_hi;
  logic [63:0]      aligned;
  logic             fill_done;

  assign raddr_lsb_unused = i_raddr[0];

  // Line B is the line after A; the 59-bit increment wraps at the top of the
  // address space and its low bits give A's index + 1 mod NUM_LINES.
  assign line_a   = addr[63:5];
  assign line_b   = addr[63:5] + 59'd1;
  assign idx_a    = line_a[IDX-1:0];
  assign idx_b    = line_b[IDX-1:0];
  assign tag_a    = line_a[58:IDX];
  assign tag_b    = line_b[58:IDX];
  assign word_sel = addr[4:3];
  assign half_sel = addr[2:1];

  // Only the last word of a line with a nonzero halfword offset spills into B.
  assign need_b = (word_sel == 2'd3) && (half_sel != 2'd0);
  assign hit_a  = valid[idx_a] && (tag_mem[idx_a] == tag_a);
  assign hit_b  = valid[idx_b] && (tag_mem[idx_b] == tag_b);
  assign hit    = hit_a && (!need_b || hit_b);

  assign fill_done = (state == FILL) && i_refill_beat && (beat_cnt == 2'd3);

  // Select the two consecutive words covering the fetch and realign them.
  // NOTE: every always_comb output is assigned on every path (here by
  //       unconditional assignments and a defaulted case) so no latch is inferred.
  always_comb begin
    word_lo = data_mem[idx_a][word_sel];
    word_hi = (word_sel == 2'd3) ? data_mem[idx_b][0]
                                 : data_mem[idx_a][word_sel + 2'd1];
    case (half_sel)
      2'd1:    aligned = {word_hi[15:0], word_lo[63:16]};
      2'd2:    aligned = {word_hi[31:0], word_lo[63:32]};
      2'd3:    aligned = {word_hi[47:0], word_lo[63:48]};
      default: aligned = word_lo;
    endcase
  end

  // Response is decoded from registered state only (FSM, address, arrays).
  assign o_valid        = (state == LOOKUP) && hit;
  assign o_rdata        = o_valid ? aligned : 64'd0;
  assign o_refill_valid = (state == REQ);

  // Control FSM, valid bits and refill request address.
  // NOTE: sequential state is written with non-blocking assignments so every
  //       flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      valid         <= '0;
      o_refill_addr <= '0;
      victim_idx    <= '0;
      victim_tag    <= '0;
      beat_cnt      <= '0;
      flush_pend    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_ren) begin
            addr  <= i_raddr[63:1];
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (i_ren) begin
              addr <= i_raddr[63:1];
            end else begin
              state <= IDLE;
            end
          end else begin
            // Missing line A is fetched first; B is re-checked afterwards.
            state <= REQ;
            if (!hit_a) begin
              victim_idx    <= idx_a;
              victim_tag    <= tag_a;
              o_refill_addr <= {line_a, 5'd0};
            end else begin
              victim_idx    <= idx_b;
              victim_tag    <= tag_b;
              o_refill_addr <= {line_b, 5'd0};
            end
          end
        end
        REQ: begin
          if (i_refill_ready) begin
            state             <= FILL;
            beat_cnt          <= 2'd0;
            valid[victim_idx] <= 1'b0;
          end
        end
        FILL: begin
          if (i_refill_beat) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) begin
              state      <= LOOKUP;
              flush_pend <= 1'b0;
              if (!flush_pend) begin
                valid[victim_idx] <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A flush wins over any valid bit set above in the same cycle. If it
      // lands while a refill is still in flight, that refill must not mark
      // its line valid when it completes.
      if (i_flush) begin
        valid <= '0;
        if ((state == REQ) || ((state == FILL) && !fill_done)) begin
          flush_pend <= 1'b1;
        end
      end
    end
  end

  // Refill beats write the victim line and its tag.
  // NOTE: tag and data arrays are intentionally not reset; the valid bits
  //       alone decide whether their contents are meaningful.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && (state == FILL) && i_refill_beat) begin
      data_mem[victim_idx][beat_cnt] <= i_refill_data;
      tag_mem[victim_idx]            <= victim_tag;
    end
  end

endmodule

// File: tb/tb_warp_icache.sv
// Testbench for warp_icache: directed scenarios plus a randomized stream,
// checked by a scoreboard against a byte-addressed backing-memory model.
module tb_warp_icache;

  localparam logic [63:0] BASE = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        i_rst_n;
  logic        i_ren;
  logic [63:0] i_raddr;
  logic        o_valid;
  logic [63:0] o_rdata;
  logic        i_flush;
  logic        o_refill_valid;
  logic [63:0] o_refill_addr;
  logic        i_refill_ready;
  logic        i_refill_beat;
  logic [63:0] i_refill_data;

  warp_icache #(.NUM_LINES(64)) dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_ren          (i_ren),
    .i_raddr        (i_raddr),
    .o_valid        (o_valid),
    .o_rdata        (o_rdata),
    .i_flush        (i_flush),
    .o_refill_valid (o_refill_valid),
    .o_refill_addr  (o_refill_addr),
    .i_refill_ready (i_refill_ready),
    .i_refill_beat  (i_refill_beat),
    .i_refill_data  (i_refill_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] exp;
    int          cyc;
  } sb_entry_t;

  sb_entry_t   sb[$];
  logic [63:0] refill_log[$];
  int          lat_log[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  int          n_resp = 0;

  // Backing-memory behaviour knobs.
  int cfg_stall = 0;
  int cfg_gap_pct = 0;
  bit cfg_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Contents of backing memory: a fixed pseudo-random byte per address.
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    logic [63:0] h;
    h = a * 64'h9E37_79B9_7F4A_7C15;
    return h[63:56] ^ h[31:24];
  endfunction

  // Eight little-endian bytes starting at a (64-bit wraparound).
  function automatic logic [63:0] bytes8(input logic [63:0] a);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mem_byte(a + 64'(k));
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    i_ren   = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic issue(input logic [63:0] a);
    sb_entry_t e;
    i_ren   = 1'b1;
    i_raddr = a;
    e.addr  = a;
    e.exp   = bytes8({a[63:1], 1'b0});
    e.cyc   = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: pop and compare whenever the cache presents a response.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (i_rst_n) begin
        if (o_valid) begin
          if (sb.size() == 0) begin
            check("spurious_valid", 64'(o_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            check($sformatf("rdata@%h", e.addr), o_rdata, e.exp);
            lat_log.push_back(cyc - e.cyc);
            n_resp++;
          end
        end else begin
          check("rdata_zero_when_idle", o_rdata, 64'd0);
        end
      end
    end
  end

  // Backing memory: accepts refill requests and returns four beats.
  initial begin
    int          mstate;
    int          stall_left;
    int          beat_idx;
    logic [63:0] line_addr;
    mstate = 0; stall_left = 0; beat_idx = 0; line_addr = '0;
    i_refill_ready = 1'b0;
    i_refill_beat  = 1'b0;
    i_refill_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!i_rst_n) begin
        mstate = 0;
        i_refill_ready = 1'b0;
        i_refill_beat  = 1'b0;
      end else begin
        case (mstate)
          0: begin
            i_refill_ready = 1'b0;
            i_refill_beat  = 1'b0;
            if (o_refill_valid) begin
              line_addr = o_refill_addr;
              refill_log.push_back(line_addr);
              check("refill_addr_aligned", 64'(line_addr[4:0]), 64'd0);
              stall_left = cfg_rand ? int'($urandom_range(0, 3)) : cfg_stall;
              beat_idx = 0;
              if (stall_left == 0) begin
                i_refill_ready = 1'b1;
                mstate = 2;
              end else begin
                mstate = 1;
              end
            end
          end
          1: begin
            check("refill_valid_held", 64'(o_refill_valid), 64'd1);
            check("refill_addr_held", o_refill_addr, line_addr);
            stall_left--;
            if (stall_left == 0) begin
              i_refill_ready = 1'b1;
              mstate = 2;
            end
          end
          default: begin
            i_refill_ready = 1'b0;
            if (cfg_gap_pct > 0 && int'($urandom_range(0, 99)) < cfg_gap_pct) begin
              i_refill_beat = 1'b0;
            end else begin
              i_refill_beat = 1'b1;
              i_refill_data = bytes8(line_addr + 64'(8 * beat_idx));
              beat_idx++;
              if (beat_idx == 4) mstate = 0;
            end
          end
        endcase
      end
    end
  end

  // Hard stop well inside the cycle budget.
  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int n0;
    int r0;
    int k;
    int issued;
    logic [63:0] a;

    i_rst_n = 1'b0;
    i_ren   = 1'b0;
    i_raddr = '0;
    i_flush = 1'b0;
    repeat (3) step();
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_rdata", o_rdata, 64'd0);
    check("reset_refill_valid", 64'(o_refill_valid), 64'd0);
    check("reset_refill_addr", o_refill_addr, 64'd0);
    i_rst_n = 1'b1;
    step();

    // Cold miss on line 0.
    n0 = refill_log.size();
    issue(BASE);
    wait_idle(100);
    check("cold_refill_cnt", 64'(refill_log.size() - n0), 64'd1);
    check("cold_refill_addr", refill_log[n0], BASE);
    check("cold_latency", 64'(lat_log[$]), 64'd7);

    // Back-to-back hits.
    n0 = refill_log.size();
    issue(BASE + 64'h8);
    step();
    issue(BASE + 64'hE);
    wait_idle(50);
    check("b2b_latency_0", 64'(lat_log[$-1]), 64'd1);
    check("b2b_latency_1", 64'(lat_log[$]), 64'd1);
    check("b2b_no_refill", 64'(refill_log.size() - n0), 64'd0);

    // Line crossing: only the second line is fetched.
    n0 = refill_log.size();
    issue(BASE + 64'h1A);
    wait_idle(100);
    check("cross_refill_cnt", 64'(refill_log.size() - n0), 64'd1);
    check("cross_refill_addr", refill_log[n0], BASE + 64'h20);
    check("cross_latency", 64'(lat_log[$]), 64'd7);

    // Conflict on index 0.
    n0 = refill_log.size();
    issue(BASE + 64'h800);
    wait_idle(100);
    issue(BASE);
    wait_idle(100);
    check("conflict_refill_cnt", 64'(refill_log.size() - n0), 64'd2);
    check("conflict_refill_1", refill_log[n0 + 1], BASE);

    // Flush while idle forces a refill of a resident line.
    issue(BASE);
    wait_idle(50);
    check("preflush_hit_latency", 64'(lat_log[$]), 64'd1);
    i_flush = 1'b1;
    step();
    n0 = refill_log.size();
    issue(BASE);
    wait_idle(100);
    check("flush_refill_cnt", 64'(refill_log.size() - n0), 64'd1);
    check("flush_latency", 64'(lat_log[$]), 64'd7);

    // Flush during FILL: line fetched twice, answered once.
    n0 = refill_log.size();
    r0 = n_resp;
    issue(BASE + 64'h40);
    k = 0;
    while (refill_log.size() == n0 && k < 20) begin step(); k++; end
    step();
    step();
    i_flush = 1'b1;
    wait_idle(100);
    check("fill_flush_refill_cnt", 64'(refill_log.size() - n0), 64'd2);
    check("fill_flush_refill_addr", refill_log[$], BASE + 64'h40);
    check("fill_flush_resp_cnt", 64'(n_resp - r0), 64'd1);

    // Backpressure: ready held low for five cycles.
    cfg_stall = 5;
    n0 = refill_log.size();
    issue(BASE + 64'h80);
    wait_idle(100);
    check("stall_latency", 64'(lat_log[$]), 64'd12);
    check("stall_refill_addr", refill_log[n0], BASE + 64'h80);
    cfg_stall = 0;

    // Reset in the middle of a fill.
    n0 = refill_log.size();
    r0 = n_resp;
    issue(BASE + 64'hC0);
    k = 0;
    while (refill_log.size() == n0 && k < 20) begin step(); k++; end
    step();
    i_rst_n = 1'b0;
    sb.delete();
    step();
    check("midreset_valid", 64'(o_valid), 64'd0);
    check("midreset_rdata", o_rdata, 64'd0);
    check("midreset_refill_valid", 64'(o_refill_valid), 64'd0);
    check("midreset_refill_addr", o_refill_addr, 64'd0);
    i_rst_n = 1'b1;
    step();
    check("midreset_no_resp", 64'(n_resp - r0), 64'd0);
    n0 = refill_log.size();
    issue(BASE);
    wait_idle(100);
    check("postreset_refill_cnt", 64'(refill_log.size() - n0), 64'd1);

    // Randomized stream with chained hits, flushes, stalls and beat gaps.
    cfg_rand = 1'b1;
    cfg_gap_pct = 25;
    issued = 0;
    k = 0;
    while (issued < 400 && k < 40000) begin
      step();
      k++;
      if (int'($urandom_range(0, 99)) < 3) i_flush = 1'b1;
      if ((sb.size() == 0 || (sb.size() == 1 && o_valid)) &&
          int'($urandom_range(0, 99)) < 70) begin
        if (int'($urandom_range(0, 99)) < 80) begin
          a = BASE + 64'($urandom_range(0, 4095));
        end else begin
          a = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
        end
        issue(a);
        issued++;
      end
    end
    wait_idle(200);
    check("random_issued", 64'(issued), 64'd400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
